// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side controller.
// Holds the controller state encoding and default widths.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } rd_state_e;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer absorbing FIFO read latency.
// Head is the oldest word; tail holds the second word.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        occ,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic [1:0]        occ_q, occ_d;

   assign occ  = occ_q;
   assign head = head_q;

   // Shift/insert so that head always holds the oldest word
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) head_d = push_data;
            else               tail_d = push_data;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd2) begin
               head_d = tail_q;
               tail_d = push_data;
            end else begin
               head_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // Buffer storage; reset empties it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side master for a 1-cycle-latency synchronous FIFO.
// Issues reads, buffers returns, streams words on valid/ready.
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              busy,
   output logic [CNT_W-1:0]  words_read
);

   rd_state_e        state_q, state_d;
   logic             inflight_q, inflight_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic [1:0]       occ;
   logic             pop;
   logic [2:0]       pend;

   fifo_rd_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (fifo_dout),
      .pop       (pop),
      .occ       (occ),
      .head      (m_data)
   );

   assign m_valid    = (occ != 2'd0);
   assign pop        = m_valid & m_ready;
   assign pend       = {1'b0, occ} + {2'b0, inflight_q};
   assign words_read = words_q;

   // State, in-flight marker and handshake counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         words_q    <= words_d;
      end
   end

   // Next state: drain finishes once nothing is buffered or pending
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = ACTIVE;
         ACTIVE:  if (!enable) state_d = DRAIN;
         DRAIN: begin
            if (enable)
               state_d = ACTIVE;
            else if (occ == 2'd0 && !inflight_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read issue: never more than two words owned (buffered + pending)
   always_comb begin
      busy       = (state_q != IDLE);
      fifo_rd    = (state_q == ACTIVE) & !fifo_empty
                 & (pend < (3'd2 + {2'b0, pop}));
      inflight_d = fifo_rd;
      words_d    = pop ? words_q + CNT_W'(1) : words_q;
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl with a queue-based FIFO model.
// Expected words are queued on FIFO write and popped on handshake.
module tb_fifo_read_ctrl;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable = 1'b0;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_rd;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [DATA_W-1:0] m_data;
   logic              busy;
   logic [CNT_W-1:0]  words_read;

   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;

   logic [DATA_W-1:0] fq[$];
   logic [DATA_W-1:0] sb[$];
   int                rd_viol = 0;
   int                n_cmp = 0;
   int                n_bad = 0;

   fifo_read_ctrl #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd    (fifo_rd),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .busy       (busy),
      .words_read (words_read)
   );

   always #5 clk = ~clk;

   // FIFO model: registered empty flag, data valid the cycle after rd
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         fq.delete();
         fifo_dout  <= '0;
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_rd) begin
            if (fifo_empty || fq.size() == 0) rd_viol++;
            else fifo_dout <= fq.pop_front();
         end
         if (wr_en) fq.push_back(wr_data);
         fifo_empty <= (fq.size() == 0);
      end
   end

   task automatic apply_reset();
      reset   = 1'b0;
      enable  = 1'b0;
      m_ready = 1'b0;
      wr_en   = 1'b0;
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic fifo_write(input logic [DATA_W-1:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      sb.push_back(v);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({fifo_rd, m_valid, busy} !== 3'b000 || m_data !== '0
          || words_read !== '0) begin
         n_bad++;
         $display("FAIL por_state: rd=%b v=%b busy=%b d=%h w=%0d want 0",
                  fifo_rd, m_valid, busy, m_data, words_read);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) fifo_write(8'h31 + 8'(i));
      m_ready = 1'b1;
      enable  = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midstream: v=%b busy=%b want 1 1", m_valid, busy);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({fifo_rd, m_valid, busy} !== 3'b000 || m_data !== '0
          || words_read !== '0) begin
         n_bad++;
         $display("FAIL async_reset: rd=%b v=%b busy=%b d=%h w=%0d want 0",
                  fifo_rd, m_valid, busy, m_data, words_read);
      end
      enable  = 1'b0;
      m_ready = 1'b0;
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || words_read !== '0) begin
         n_bad++;
         $display("FAIL post_release: busy=%b w=%0d want 0 0",
                  busy, words_read);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_after: busy=%b v=%b want 0 0", busy, m_valid);
      end
   endtask

   task automatic test_stream();
      int pops;
      int gaps;
      int last;
      int viol0;
      logic [DATA_W-1:0] exp;
      apply_reset();
      for (int i = 10; i < 20; i++) fifo_write(8'(i));
      viol0   = rd_viol;
      m_ready = 1'b1;
      enable  = 1'b1;
      pops = 0;
      gaps = 0;
      last = -1;
      for (int c = 0; c < 40 && pops < 10; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            exp = sb.size() ? sb.pop_front() : 'x;
            n_cmp++;
            if (m_data !== exp) begin
               n_bad++;
               $display("FAIL stream_data: got %h want %h", m_data, exp);
            end
            if (last >= 0 && c != last + 1) gaps++;
            last = c;
            pops++;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (pops != 10 || gaps != 0) begin
         n_bad++;
         $display("FAIL stream_rate: pops=%0d gaps=%0d want 10 0",
                  pops, gaps);
      end
      n_cmp++;
      if (words_read !== CNT_W'(10)) begin
         n_bad++;
         $display("FAIL stream_count: got %0d want 10", words_read);
      end
      n_cmp++;
      if (rd_viol != viol0) begin
         n_bad++;
         $display("FAIL stream_rd_empty: got %0d want %0d", rd_viol, viol0);
      end
   endtask

   task automatic test_backpressure();
      int rds;
      int pops;
      logic [DATA_W-1:0] exp;
      apply_reset();
      for (int i = 0; i < 4; i++) fifo_write(8'hA0 + 8'(i));
      m_ready = 1'b0;
      enable  = 1'b1;
      rds = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (fifo_rd) rds++;
         if (c >= 2) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== sb[0]) begin
               n_bad++;
               $display("FAIL bp_hold: v=%b d=%h want 1 %h",
                        m_valid, m_data, sb[0]);
            end
         end
      end
      n_cmp++;
      if (rds != 2) begin
         n_bad++;
         $display("FAIL bp_reads: got %0d want 2", rds);
      end
      n_cmp++;
      if (dut.u_skid.occ_q !== 2'd2) begin
         n_bad++;
         $display("FAIL bp_occ: got %0d want 2", dut.u_skid.occ_q);
      end
      m_ready = 1'b1;
      pops = 0;
      for (int c = 0; c < 20 && pops < 4; c++) begin
         if (m_valid && m_ready) begin
            exp = sb.size() ? sb.pop_front() : 'x;
            n_cmp++;
            if (m_data !== exp) begin
               n_bad++;
               $display("FAIL bp_data: got %h want %h", m_data, exp);
            end
            pops++;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (pops != 4 || words_read !== CNT_W'(4)) begin
         n_bad++;
         $display("FAIL bp_total: pops=%0d w=%0d want 4 4", pops, words_read);
      end
   endtask

   task automatic test_drain();
      int rds;
      int pops;
      int pop_c;
      int low_c;
      logic found;
      logic busy_at_pop;
      logic [DATA_W-1:0] exp;
      apply_reset();
      for (int i = 0; i < 5; i++) fifo_write(8'h70 + 8'(i));
      m_ready = 1'b1;
      enable  = 1'b1;
      found   = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         found = fifo_rd;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL drain_first_rd: got none want 1");
      end
      enable = 1'b0;
      rds = 0;
      pops = 0;
      pop_c = -1;
      low_c = -1;
      busy_at_pop = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (fifo_rd) rds++;
         if (busy === 1'b0 && low_c < 0 && pops > 0) low_c = c;
         if (m_valid && m_ready) begin
            exp = sb.size() ? sb.pop_front() : 'x;
            n_cmp++;
            if (m_data !== exp) begin
               n_bad++;
               $display("FAIL drain_data: got %h want %h", m_data, exp);
            end
            pops++;
            pop_c = c;
            busy_at_pop = busy;
         end
      end
      n_cmp++;
      if (rds != 0 || pops != 1) begin
         n_bad++;
         $display("FAIL drain_counts: rds=%0d pops=%0d want 0 1", rds, pops);
      end
      n_cmp++;
      if (busy_at_pop !== 1'b1 || low_c <= pop_c || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_busy: at_pop=%b pop=%0d low=%0d now=%b",
                  busy_at_pop, pop_c, low_c, busy);
      end
   endtask

   task automatic test_empty_edge();
      int rds;
      int vals;
      int viol0;
      logic [DATA_W-1:0] exp;
      apply_reset();
      m_ready = 1'b1;
      enable  = 1'b1;
      rds = 0;
      repeat (3) begin
         @(negedge clk);
         if (fifo_rd) rds++;
      end
      n_cmp++;
      if (rds != 0) begin
         n_bad++;
         $display("FAIL empty_idle_rd: got %0d want 0", rds);
      end
      viol0 = rd_viol;
      fifo_write(8'h5A);
      rds = 0;
      vals = 0;
      for (int c = 0; c < 8; c++) begin
         if (fifo_rd) rds++;
         if (m_valid) vals++;
         if (m_valid && m_ready) begin
            exp = sb.size() ? sb.pop_front() : 'x;
            n_cmp++;
            if (m_data !== exp) begin
               n_bad++;
               $display("FAIL empty_data: got %h want %h", m_data, exp);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (rds != 1 || vals != 1 || rd_viol != viol0) begin
         n_bad++;
         $display("FAIL empty_edge: rds=%0d vals=%0d viol=%0d want 1 1 %0d",
                  rds, vals, rd_viol, viol0);
      end
   endtask

   task automatic test_wrap();
      int pops;
      logic [CNT_W-1:0] expw;
      logic [DATA_W-1:0] exp;
      apply_reset();
      for (int i = 0; i < 17; i++) fifo_write(8'($urandom_range(0, 255)));
      m_ready = 1'b1;
      enable  = 1'b1;
      pops = 0;
      for (int c = 0; c < 60 && pops < 17; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            exp = sb.size() ? sb.pop_front() : 'x;
            n_cmp++;
            if (m_data !== exp) begin
               n_bad++;
               $display("FAIL wrap_data: got %h want %h", m_data, exp);
            end
            pops++;
         end
      end
      @(negedge clk);
      expw = CNT_W'(17 % (1 << CNT_W));
      n_cmp++;
      if (pops != 17 || words_read !== expw) begin
         n_bad++;
         $display("FAIL wrap_count: pops=%0d w=%0d want 17 %0d",
                  pops, words_read, expw);
      end
   endtask

   initial begin
      reset = 1'b0;
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_drain();
      test_empty_edge();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
